// File: rtl/snake_pkg.sv
// Shared definitions for the snake game logic and the world memory:
// cell codes, directions, grid size, FSM encoding and the food LFSR step.
package snake_pkg;

   localparam int unsigned GRID_N = 15;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_FOOD  = 2'b01;
   localparam logic [1:0] CELL_SNAKE = 2'b10;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StWrHead,
      StWrTail,
      StFoodRd,
      StFoodWr,
      StOver
   } state_e;

   // x^8+x^6+x^5+x^4+1, Fibonacci form, shifting left
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer of snake body coordinates {x, y}; head is the newest entry.
// Reset preloads the three-cell starting snake along row 1.
module snake_body_fifo #(
   parameter int unsigned MAX_LEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [4:0] push_x,
   input  logic [4:0] push_y,
   input  logic       pop,
   output logic [4:0] head_x,
   output logic [4:0] head_y,
   output logic [4:0] tail_x,
   output logic [4:0] tail_y,
   output logic [5:0] count
);

   localparam int unsigned PtrW = $clog2(MAX_LEN);

   logic [9:0]      mem_q [MAX_LEN];
   logic [PtrW-1:0] head_q;
   logic [PtrW-1:0] tail_q;
   logic [PtrW-1:0] head_inc;
   logic [PtrW-1:0] tail_inc;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head_inc = ptr_inc(head_q);
   assign tail_inc = ptr_inc(tail_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            mem_q[i] <= '0;
         end
         mem_q[0] <= {5'd1, 5'd1};
         mem_q[1] <= {5'd2, 5'd1};
         mem_q[2] <= {5'd3, 5'd1};
         head_q   <= PtrW'(2);
         tail_q   <= '0;
         count    <= 6'd3;
      end else begin
         if (push) begin
            mem_q[head_inc] <= {push_x, push_y};
            head_q          <= head_inc;
         end
         if (pop) begin
            tail_q <= tail_inc;
         end
         if (push && !pop) begin
            count <= count + 6'd1;
         end else if (pop && !push) begin
            count <= count - 6'd1;
         end
      end
   end

   assign {head_x, head_y} = mem_q[head_q];
   assign {tail_x, tail_y} = mem_q[tail_q];

endmodule

// File: rtl/snake_engine.sv
// Snake game-logic FSM; sole writer of the 15x15 world memory. Moves the head,
// erases or keeps the tail, detects collisions and places food via an LFSR.
module snake_engine #(
   parameter int unsigned GRID_N    = 15,
   parameter int unsigned MAX_LEN   = 32,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic [1:0] dir_in,
   input  logic [1:0] mem_data_in,
   output logic [4:0] mem_x,
   output logic [4:0] mem_y,
   output logic       mem_read_en,
   output logic [1:0] mem_data_out,
   output logic       busy,
   output logic       game_over,
   output logic [5:0] length,
   output logic [7:0] score
);

   import snake_pkg::*;

   state_e     state_q;
   logic [1:0] dir_q;
   logic       eat_q;
   logic [5:0] length_q;
   logic [7:0] score_q;
   logic [7:0] lfsr_q;
   logic [4:0] mem_x_q;
   logic [4:0] mem_y_q;
   logic       mem_read_en_q;
   logic [1:0] mem_data_out_q;
   logic       busy_q;
   logic       game_over_q;

   logic [4:0] head_x, head_y, tail_x, tail_y;
   logic [5:0] fifo_count;
   logic       push, pop, full;

   logic [1:0] dir_new;
   logic [5:0] nx, ny;
   logic       wall;
   logic [7:0] lfsr_nxt;
   logic       cand_zero;
   logic       mem_empty;

   assign push = (state_q == StWrHead);
   assign pop  = (state_q == StWrTail);
   assign full = (fifo_count >= 6'(MAX_LEN));

   snake_body_fifo #(
      .MAX_LEN (MAX_LEN)
   ) u_body (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .push_x (mem_x_q),
      .push_y (mem_y_q),
      .pop    (pop),
      .head_x (head_x),
      .head_y (head_y),
      .tail_x (tail_x),
      .tail_y (tail_y),
      .count  (fifo_count)
   );

   always_comb begin
      dir_new = (dir_in == (dir_q ^ 2'b10)) ? dir_q : dir_in;
      nx = {1'b0, head_x};
      ny = {1'b0, head_y};
      unique case (dir_new)
         DIR_UP:    ny = ny - 6'd1;
         DIR_RIGHT: nx = nx + 6'd1;
         DIR_DOWN:  ny = ny + 6'd1;
         DIR_LEFT:  nx = nx - 6'd1;
      endcase
      // Underflow from 1 wraps to 63, which the upper bound also catches
      wall = (nx == 6'd0) || (ny == 6'd0) || (nx > 6'(GRID_N)) || (ny > 6'(GRID_N));
      lfsr_nxt  = lfsr_next(lfsr_q);
      cand_zero = (lfsr_q[3:0] == 4'd0) || (lfsr_q[7:4] == 4'd0);
      mem_empty = (mem_data_in == CELL_EMPTY) || (mem_data_in == 2'b11);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         dir_q          <= DIR_RIGHT;
         eat_q          <= 1'b0;
         length_q       <= 6'd3;
         score_q        <= 8'd0;
         lfsr_q         <= LFSR_SEED;
         mem_x_q        <= 5'd1;
         mem_y_q        <= 5'd1;
         mem_read_en_q  <= 1'b1;
         mem_data_out_q <= CELL_EMPTY;
         busy_q         <= 1'b0;
         game_over_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (step) begin
                  dir_q <= dir_new;
                  if (wall) begin
                     state_q     <= StOver;
                     game_over_q <= 1'b1;
                  end else begin
                     state_q <= StCheck;
                     busy_q  <= 1'b1;
                     mem_x_q <= nx[4:0];
                     mem_y_q <= ny[4:0];
                  end
               end
            end
            StCheck: begin
               if (mem_data_in == CELL_SNAKE) begin
                  state_q     <= StOver;
                  busy_q      <= 1'b0;
                  game_over_q <= 1'b1;
               end else begin
                  eat_q          <= (mem_data_in == CELL_FOOD);
                  state_q        <= StWrHead;
                  mem_read_en_q  <= 1'b0;
                  mem_data_out_q <= CELL_SNAKE;
               end
            end
            StWrHead: begin
               mem_data_out_q <= CELL_EMPTY;
               if (eat_q) begin
                  score_q <= score_q + 8'd1;
               end
               if (eat_q && !full) begin
                  length_q      <= length_q + 6'd1;
                  state_q       <= StFoodRd;
                  mem_read_en_q <= 1'b1;
                  mem_x_q       <= {1'b0, lfsr_q[3:0]};
                  mem_y_q       <= {1'b0, lfsr_q[7:4]};
               end else begin
                  // Tail is latched here, before this edge's push can overwrite it when full
                  state_q <= StWrTail;
                  mem_x_q <= tail_x;
                  mem_y_q <= tail_y;
               end
            end
            StWrTail: begin
               mem_read_en_q <= 1'b1;
               if (eat_q) begin
                  state_q <= StFoodRd;
                  mem_x_q <= {1'b0, lfsr_q[3:0]};
                  mem_y_q <= {1'b0, lfsr_q[7:4]};
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            StFoodRd: begin
               if (!cand_zero && mem_empty) begin
                  state_q        <= StFoodWr;
                  mem_read_en_q  <= 1'b0;
                  mem_data_out_q <= CELL_FOOD;
               end else begin
                  lfsr_q  <= lfsr_nxt;
                  mem_x_q <= {1'b0, lfsr_nxt[3:0]};
                  mem_y_q <= {1'b0, lfsr_nxt[7:4]};
               end
            end
            StFoodWr: begin
               lfsr_q         <= lfsr_nxt;
               state_q        <= StIdle;
               busy_q         <= 1'b0;
               mem_read_en_q  <= 1'b1;
               mem_data_out_q <= CELL_EMPTY;
            end
            StOver: begin
               game_over_q <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // rst forces read so a write state caught by reset never commits
   assign mem_read_en  = mem_read_en_q | rst;
   assign mem_x        = mem_x_q;
   assign mem_y        = mem_y_q;
   assign mem_data_out = mem_data_out_q;
   assign busy         = busy_q;
   assign game_over    = game_over_q;
   assign length       = length_q;
   assign score        = score_q;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine with a behavioural 15x15 world memory
// that logs every write the engine issues.
module tb_snake_engine;
   import snake_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       step = 1'b0;
   logic [1:0] dir_in = 2'b01;
   logic [1:0] mem_data_in;
   logic [4:0] mem_x, mem_y;
   logic       mem_read_en;
   logic [1:0] mem_data_out;
   logic       busy, game_over;
   logic [5:0] length;
   logic [7:0] score;

   logic       poke_en = 1'b0;
   logic [4:0] poke_x = '0;
   logic [4:0] poke_y = '0;
   logic [1:0] poke_val = '0;

   logic [1:0]  world [32][32];
   logic [11:0] wlog [$];

   int passed = 0;
   int total  = 0;
   int base;
   int cyc;

   typedef struct {
      logic [1:0] dir;
      logic [4:0] hx, hy, tx, ty;
   } mv_t;
   mv_t mv [7];

   snake_engine dut (
      .clk          (clk),
      .rst          (rst),
      .step         (step),
      .dir_in       (dir_in),
      .mem_data_in  (mem_data_in),
      .mem_x        (mem_x),
      .mem_y        (mem_y),
      .mem_read_en  (mem_read_en),
      .mem_data_out (mem_data_out),
      .busy         (busy),
      .game_over    (game_over),
      .length       (length),
      .score        (score)
   );

   always #5 clk = ~clk;

   assign mem_data_in = world[mem_x][mem_y];

   always @(posedge clk) begin
      if (!mem_read_en) begin
         wlog.push_back({mem_x, mem_y, mem_data_out});
         world[mem_x][mem_y] <= mem_data_out;
      end
      if (rst) begin
         for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
               world[i][j] <= CELL_EMPTY;
         world[1][1] <= CELL_SNAKE;
         world[2][1] <= CELL_SNAKE;
         world[3][1] <= CELL_SNAKE;
      end else if (poke_en) begin
         world[poke_x][poke_y] <= poke_val;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic chk_wr(input string name, input int idx, input logic [4:0] x, input logic [4:0] y,
                         input logic [1:0] d);
      if (idx < wlog.size()) chk(name, 32'(wlog[idx]), {20'd0, x, y, d});
      else chk({name, " missing"}, 32'(wlog.size()), 32'(idx + 1));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic poke(input logic [4:0] x, input logic [4:0] y, input logic [1:0] v);
      @(negedge clk);
      poke_en = 1'b1; poke_x = x; poke_y = y; poke_val = v;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Counts busy cycles after the step edge; a stuck FSM ends at 1000
   task automatic do_step(input logic [1:0] d, output int n);
      @(negedge clk);
      step = 1'b1;
      dir_in = d;
      @(negedge clk);
      step = 1'b0;
      n = 0;
      while (busy && n < 1000) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      mv[0] = '{2'b01, 5'd4, 5'd1, 5'd1, 5'd1};
      mv[1] = '{2'b10, 5'd4, 5'd2, 5'd2, 5'd1};
      mv[2] = '{2'b11, 5'd3, 5'd2, 5'd3, 5'd1};
      mv[3] = '{2'b00, 5'd3, 5'd1, 5'd4, 5'd1};
      mv[4] = '{2'b01, 5'd4, 5'd1, 5'd4, 5'd2};
      mv[5] = '{2'b11, 5'd5, 5'd1, 5'd3, 5'd2};  // reverse of right: ignored
      mv[6] = '{2'b10, 5'd5, 5'd2, 5'd3, 5'd1};

      do_reset();
      chk("rst busy", 32'(busy), 0);
      chk("rst game_over", 32'(game_over), 0);
      chk("rst length", 32'(length), 3);
      chk("rst score", 32'(score), 0);
      chk("rst read_en", 32'(mem_read_en), 1);
      chk("rst mem_x", 32'(mem_x), 1);
      chk("rst mem_y", 32'(mem_y), 1);
      chk("rst data_out", 32'(mem_data_out), 0);

      // Plain moves from the table
      for (int i = 0; i < 7; i++) begin
         base = wlog.size();
         do_step(mv[i].dir, cyc);
         chk($sformatf("mv%0d busy cycles", i), 32'(cyc), 3);
         chk($sformatf("mv%0d n writes", i), 32'(wlog.size() - base), 2);
         chk_wr($sformatf("mv%0d head wr", i), base, mv[i].hx, mv[i].hy, CELL_SNAKE);
         chk_wr($sformatf("mv%0d tail wr", i), base + 1, mv[i].tx, mv[i].ty, CELL_EMPTY);
         chk($sformatf("mv%0d length", i), 32'(length), 3);
      end

      // Reverse request ignored, then upward wall hit
      do_reset();
      base = wlog.size();
      do_step(2'b11, cyc);
      chk_wr("rev head wr", base, 5'd4, 5'd1, CELL_SNAKE);
      base = wlog.size();
      do_step(2'b00, cyc);
      chk("up wall busy", 32'(cyc), 0);
      chk("up wall game_over", 32'(game_over), 1);
      chk("up wall writes", 32'(wlog.size() - base), 0);

      // Right wall
      do_reset();
      for (int i = 0; i < 12; i++) do_step(2'b01, cyc);
      chk_wr("x15 head wr", wlog.size() - 2, 5'd15, 5'd1, CELL_SNAKE);
      chk("x15 game_over", 32'(game_over), 0);
      base = wlog.size();
      do_step(2'b01, cyc);
      chk("r wall game_over", 32'(game_over), 1);
      chk("r wall busy", 32'(cyc), 0);
      do_step(2'b10, cyc);
      do_step(2'b01, cyc);
      chk("over writes", 32'(wlog.size() - base), 0);
      chk("over busy", 32'(busy), 0);
      chk("over sticky", 32'(game_over), 1);

      // Eat food at (4,1); seed A5 places new food at (5,10) first try
      do_reset();
      poke(5'd4, 5'd1, CELL_FOOD);
      base = wlog.size();
      do_step(2'b01, cyc);
      chk("eat busy cycles", 32'(cyc), 4);
      chk("eat n writes", 32'(wlog.size() - base), 2);
      chk_wr("eat head wr", base, 5'd4, 5'd1, CELL_SNAKE);
      chk_wr("eat food wr", base + 1, 5'd5, 5'd10, CELL_FOOD);
      chk("eat length", 32'(length), 4);
      chk("eat score", 32'(score), 1);
      chk("eat world food", 32'(world[5][10]), 32'(CELL_FOOD));

      // Self collision, then reset restores counters
      poke(5'd5, 5'd1, CELL_SNAKE);
      base = wlog.size();
      do_step(2'b01, cyc);
      chk("hit busy cycles", 32'(cyc), 1);
      chk("hit game_over", 32'(game_over), 1);
      chk("hit writes", 32'(wlog.size() - base), 0);
      do_reset();
      chk("post rst length", 32'(length), 3);
      chk("post rst score", 32'(score), 0);
      chk("post rst game_over", 32'(game_over), 0);

      // Reset landing on WR_HEAD
      @(negedge clk);
      step = 1'b1;
      dir_in = 2'b01;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
      chk("wrhead reached", 32'(mem_read_en), 0);
      base = wlog.size();
      rst = 1'b1;
      #1;
      chk("rst gates write", 32'(mem_read_en), 1);
      @(negedge clk);
      rst = 1'b0;
      chk("mid rst writes", 32'(wlog.size() - base), 0);
      chk("mid rst busy", 32'(busy), 0);
      chk("mid rst read_en", 32'(mem_read_en), 1);
      chk("mid rst length", 32'(length), 3);
      base = wlog.size();
      do_step(2'b01, cyc);
      chk_wr("after rst head wr", base, 5'd4, 5'd1, CELL_SNAKE);
      chk_wr("after rst tail wr", base + 1, 5'd1, 5'd1, CELL_EMPTY);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
